mcb_reset_sequencer: RTL and testbench

//   Power-up/recovery sequencer downstream of clock_reset. Qualifies bufpll_mcb_lock, pulses the MCB

---
 rtl/mcb_reset_sequencer.sv | 122 ++++++++++++
 tb/tb_mcb_reset_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_reset_sequencer.sv
// rtl/mcb_reset_sequencer.sv - MCB bring-up sequencer: lock qualify, MCB reset pulse, calibration wait/retry, FB release
// Runs on the MCB DRP clock; every frame_buffer reset is derived from its registered outputs.
module mcb_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int MCB_RST_CYCLES     = 8,
  parameter int CALIB_TIMEOUT      = 65535,
  parameter int MAX_RETRY          = 3,
  parameter int FB_RST_DELAY       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bufpll_mcb_lock,
  input  logic       calib_done,
  output logic       mcb_rst,
  output logic       fb_reset,
  output logic       init_done,
  output logic       calib_err,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_LOCK_STB  = 3'd2,
    S_MCB_RST   = 3'd3,
    S_WAIT_CAL  = 3'd4,
    S_FB_REL    = 3'd5,
    S_RUN       = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] MCB_LAST   = 16'(MCB_RST_CYCLES - 1);
  localparam logic [15:0] CAL_LAST   = 16'(CALIB_TIMEOUT - 1);
  localparam logic [15:0] FB_LAST    = 16'(FB_RST_DELAY - 1);
  localparam logic [1:0]  RETRY_LAST = 2'(MAX_RETRY);

  logic [1:0]  lock_sync_q;
  logic [1:0]  cal_sync_q;
  logic        lock_s;
  logic        cal_s;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  retry_q, retry_d;
  logic        mcb_rst_q, fb_reset_q, init_done_q, calib_err_q;

  assign lock_s = lock_sync_q[1];
  assign cal_s  = cal_sync_q[1];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE:      state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_s) state_d = S_LOCK_STB;
      S_LOCK_STB: begin
        if (!lock_s)                state_d = S_WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = S_MCB_RST;
      end
      S_MCB_RST:   if (cnt_q == MCB_LAST) state_d = S_WAIT_CAL;
      S_WAIT_CAL: begin
        // calib_done arriving on the timeout cycle still counts as success
        if (cal_s) begin
          state_d = S_FB_REL;
        end else if (cnt_q == CAL_LAST) begin
          if (retry_q == RETRY_LAST) begin
            state_d = S_ERR;
          end else begin
            state_d = S_MCB_RST;
            retry_d = retry_q + 2'd1;
          end
        end
      end
      S_FB_REL: begin
        if (!cal_s)                state_d = S_MCB_RST;
        else if (cnt_q == FB_LAST) state_d = S_RUN;
      end
      S_RUN:       if (!cal_s) state_d = S_MCB_RST;
      S_ERR:       state_d = S_ERR;
      default:     state_d = S_IDLE;
    endcase
    // Losing the PLL lock ends the session from any MCB-active state
    if (!lock_s && (state_q inside {[S_MCB_RST:S_RUN]})) begin
      state_d = S_WAIT_LOCK;
      retry_d = 2'd0;
    end
    cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_sync_q <= 2'b00;
      cal_sync_q  <= 2'b00;
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      retry_q     <= 2'd0;
      mcb_rst_q   <= 1'b1;
      fb_reset_q  <= 1'b1;
      init_done_q <= 1'b0;
      calib_err_q <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], bufpll_mcb_lock};
      cal_sync_q  <= {cal_sync_q[0], calib_done};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      mcb_rst_q   <= state_d inside {S_IDLE, S_WAIT_LOCK, S_LOCK_STB, S_MCB_RST, S_ERR};
      fb_reset_q  <= (state_d != S_RUN);
      init_done_q <= (state_d == S_RUN);
      calib_err_q <= (state_d == S_ERR);
    end
  end

  assign mcb_rst   = mcb_rst_q;
  assign fb_reset  = fb_reset_q;
  assign init_done = init_done_q;
  assign calib_err = calib_err_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mcb_reset_sequencer.sv
// tb/tb_mcb_reset_sequencer.sv - scoreboard bench for mcb_reset_sequencer
// dut_a runs default parameters; dut_b uses a short calibration timeout and MAX_RETRY=2.
module tb_mcb_reset_sequencer;

  localparam int LSC   = 16;
  localparam int MRC   = 8;
  localparam int FBD   = 4;
  localparam int TO_B  = 100;

  typedef struct {
    logic [8:0] v;
    int         c;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       lock_a, cal_a, lock_b, cal_b;
  logic       mrst_a, fbr_a, ini_a, err_a;
  logic       mrst_b, fbr_b, ini_b, err_b;
  logic [1:0] rc_a, rc_b;
  logic [2:0] st_a, st_b;

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         rel_cyc = 0;
  logic [2:0] last_a = 3'd0;
  logic [2:0] last_b = 3'd0;
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  obs_t       obs_a[$];
  obs_t       obs_b[$];
  obs_t       mon_a, mon_b;

  mcb_reset_sequencer dut_a (
    .clk(clk), .reset(reset), .bufpll_mcb_lock(lock_a), .calib_done(cal_a),
    .mcb_rst(mrst_a), .fb_reset(fbr_a), .init_done(ini_a), .calib_err(err_a),
    .retry_cnt(rc_a), .state(st_a)
  );

  mcb_reset_sequencer #(.CALIB_TIMEOUT(TO_B), .MAX_RETRY(2)) dut_b (
    .clk(clk), .reset(reset), .bufpll_mcb_lock(lock_b), .calib_done(cal_b),
    .mcb_rst(mrst_b), .fb_reset(fbr_b), .init_done(ini_b), .calib_err(err_b),
    .retry_cnt(rc_b), .state(st_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every state change with the full output vector and the cycle it happened on
  always @(negedge clk) begin
    if (st_a !== last_a) begin
      mon_a.v = {st_a, mrst_a, fbr_a, ini_a, err_a, rc_a};
      mon_a.c = cyc;
      obs_a.push_back(mon_a);
    end
    if (st_b !== last_b) begin
      mon_b.v = {st_b, mrst_b, fbr_b, ini_b, err_b, rc_b};
      mon_b.c = cyc;
      obs_b.push_back(mon_b);
    end
    last_a <= st_a;
    last_b <= st_b;
  end

  function automatic logic [8:0] ev(input logic [2:0] s, input logic [1:0] r);
    logic m;
    m = (s <= 3'd3) || (s == 3'd7);
    return {s, m, s != 3'd6, s == 3'd6, s == 3'd7, r};
  endfunction

  task automatic apply_reset(input logic la, input logic ca, input logic lb, input logic cb);
    reset = 1'b1;
    lock_a = la; cal_a = ca; lock_b = lb; cal_b = cb;
    repeat (3) @(negedge clk);
    #1;
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_obs(input bit use_b, input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if ((use_b ? obs_b.size() : obs_a.size()) >= n) break;
      @(posedge clk); #1;
    end
    #1;
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 2000 && cyc < target; k++) begin
      @(posedge clk); #1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lock_a = 1'b1; cal_a = 1'b1; lock_b = 1'b1; cal_b = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if ({st_a, mrst_a, fbr_a, ini_a, err_a, rc_a} !== ev(3'd0, 2'd0)) begin
      n_fail++; $display("FAIL reset_a: got %h want %h", {st_a, mrst_a, fbr_a, ini_a, err_a, rc_a}, ev(3'd0, 2'd0));
    end
    n_tests++;
    if ({st_b, mrst_b, fbr_b, ini_b, err_b, rc_b} !== ev(3'd0, 2'd0)) begin
      n_fail++; $display("FAIL reset_b: got %h want %h", {st_b, mrst_b, fbr_b, ini_b, err_b, rc_b}, ev(3'd0, 2'd0));
    end
  endtask

  task automatic test_min_latency();
    logic [8:0] e; obs_t o; int tc[$];
    apply_reset(1'b1, 1'b1, 1'b0, 1'b0);
    for (int s = 1; s <= 6; s++) exp_a.push_back(ev(3'(s), 2'd0));
    wait_obs(1'b0, 6, 200);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_tests++;
      if (obs_a.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL latency seq: got none want %h", e);
      end else begin
        o = obs_a.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL latency seq: got %h want %h", o.v, e); end
      end
    end
    n_tests++;
    if ((tc[5] - rel_cyc) < (2 + LSC + MRC + 3 + FBD - 2) || (tc[5] - rel_cyc) > (2 + LSC + MRC + 3 + FBD + 2)) begin
      n_fail++; $display("FAIL latency: got %0d want %0d +/-2", tc[5] - rel_cyc, 2 + LSC + MRC + 3 + FBD);
    end
  endtask

  task automatic test_nominal();
    logic [8:0] e; obs_t o; int tc[$]; int t_cal;
    apply_reset(1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 1; s <= 4; s++) exp_a.push_back(ev(3'(s), 2'd0));
    wait_obs(1'b0, 4, 100);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_tests++;
      if (obs_a.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL nominal seq: got none want %h", e);
      end else begin
        o = obs_a.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL nominal seq: got %h want %h", o.v, e); end
      end
    end
    n_tests++;
    if (tc[2] - tc[1] !== LSC) begin n_fail++; $display("FAIL lock_qual: got %0d want %0d", tc[2] - tc[1], LSC); end
    n_tests++;
    if (tc[3] - tc[2] !== MRC) begin n_fail++; $display("FAIL mcb_rst_width: got %0d want %0d", tc[3] - tc[2], MRC); end
    wait_cyc(tc[3] + 20);
    cal_a = 1'b1; t_cal = cyc;
    exp_a.push_back(ev(3'd5, 2'd0)); exp_a.push_back(ev(3'd6, 2'd0));
    wait_obs(1'b0, 2, 50);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_tests++;
      if (obs_a.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL nominal rel: got none want %h", e);
      end else begin
        o = obs_a.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL nominal rel: got %h want %h", o.v, e); end
      end
    end
    n_tests++;
    if (tc[5] - t_cal !== 3 + FBD) begin n_fail++; $display("FAIL cal_to_init: got %0d want %0d", tc[5] - t_cal, 3 + FBD); end
  endtask

  task automatic test_lock_glitch();
    logic [8:0] e; obs_t o; int tc[$];
    apply_reset(1'b1, 1'b1, 1'b0, 1'b0);
    exp_a.push_back(ev(3'd1, 2'd0)); exp_a.push_back(ev(3'd2, 2'd0));
    wait_obs(1'b0, 2, 50);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_tests++;
      if (obs_a.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL glitch pre: got none want %h", e);
      end else begin
        o = obs_a.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL glitch pre: got %h want %h", o.v, e); end
      end
    end
    wait_cyc(tc[1] + 10);
    lock_a = 1'b0;
    repeat (3) @(posedge clk);
    #2 lock_a = 1'b1;
    for (int s = 1; s <= 6; s++) exp_a.push_back(ev(3'(s), 2'd0));
    wait_obs(1'b0, 6, 100);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_tests++;
      if (obs_a.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL glitch post: got none want %h", e);
      end else begin
        o = obs_a.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL glitch post: got %h want %h", o.v, e); end
      end
    end
    n_tests++;
    if (tc[4] - tc[3] !== LSC) begin n_fail++; $display("FAIL glitch requal: got %0d want %0d", tc[4] - tc[3], LSC); end
  endtask

  task automatic test_timeout_err();
    logic [8:0] e; obs_t o; int tc[$];
    apply_reset(1'b0, 1'b0, 1'b1, 1'b0);
    exp_b.push_back(ev(3'd1, 2'd0)); exp_b.push_back(ev(3'd2, 2'd0));
    for (int r = 0; r <= 2; r++) begin
      exp_b.push_back(ev(3'd3, 2'(r))); exp_b.push_back(ev(3'd4, 2'(r)));
    end
    exp_b.push_back(ev(3'd7, 2'd2));
    wait_obs(1'b1, 9, 600);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front(); n_tests++;
      if (obs_b.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL timeout seq: got none want %h", e);
      end else begin
        o = obs_b.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL timeout seq: got %h want %h", o.v, e); end
      end
    end
    n_tests++;
    if (tc[8] - tc[7] !== TO_B) begin n_fail++; $display("FAIL timeout len: got %0d want %0d", tc[8] - tc[7], TO_B); end
    cal_b = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    n_tests++;
    if ({st_b, mrst_b, fbr_b, ini_b, err_b, rc_b} !== ev(3'd7, 2'd2) || obs_b.size() != 0) begin
      n_fail++; $display("FAIL err_hold: got %h want %h", {st_b, mrst_b, fbr_b, ini_b, err_b, rc_b}, ev(3'd7, 2'd2));
    end
  endtask

  task automatic test_retry_success();
    logic [8:0] e; obs_t o; int tc[$];
    apply_reset(1'b0, 1'b0, 1'b1, 1'b0);
    exp_b.push_back(ev(3'd1, 2'd0)); exp_b.push_back(ev(3'd2, 2'd0));
    exp_b.push_back(ev(3'd3, 2'd0)); exp_b.push_back(ev(3'd4, 2'd0));
    exp_b.push_back(ev(3'd3, 2'd1)); exp_b.push_back(ev(3'd4, 2'd1));
    wait_obs(1'b1, 6, 400);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front(); n_tests++;
      if (obs_b.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL retry seq: got none want %h", e);
      end else begin
        o = obs_b.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL retry seq: got %h want %h", o.v, e); end
      end
    end
    wait_cyc(tc[5] + 30);
    cal_b = 1'b1;
    exp_b.push_back(ev(3'd5, 2'd1)); exp_b.push_back(ev(3'd6, 2'd1));
    wait_obs(1'b1, 2, 50);
    repeat (10) @(posedge clk);
    #2;
    exp_b.push_back(ev(3'd1, 2'd0));
    lock_b = 1'b0;
    wait_obs(1'b1, 3, 20);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front(); n_tests++;
      if (obs_b.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL retry run: got none want %h", e);
      end else begin
        o = obs_b.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL retry run: got %h want %h", o.v, e); end
      end
    end
    n_tests++;
    if (tc[8] - tc[7] < 10) begin n_fail++; $display("FAIL retry held: got %0d cycles in run want >= 10", tc[8] - tc[7]); end
  endtask

  task automatic test_timeout_boundary();
    logic [8:0] e; obs_t o; int tc[$];
    apply_reset(1'b0, 1'b0, 1'b1, 1'b0);
    for (int s = 1; s <= 4; s++) exp_b.push_back(ev(3'(s), 2'd0));
    wait_obs(1'b1, 4, 100);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front(); n_tests++;
      if (obs_b.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL boundary pre: got none want %h", e);
      end else begin
        o = obs_b.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL boundary pre: got %h want %h", o.v, e); end
      end
    end
    wait_cyc(tc[3] + TO_B - 3);
    cal_b = 1'b1;
    exp_b.push_back(ev(3'd5, 2'd0)); exp_b.push_back(ev(3'd6, 2'd0));
    wait_obs(1'b1, 2, 50);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front(); n_tests++;
      if (obs_b.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL boundary win: got none want %h", e);
      end else begin
        o = obs_b.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL boundary win: got %h want %h", o.v, e); end
      end
    end
    n_tests++;
    if (tc[4] - tc[3] !== TO_B) begin n_fail++; $display("FAIL boundary cycle: got %0d want %0d", tc[4] - tc[3], TO_B); end
  endtask

  task automatic test_lock_loss();
    logic [8:0] e; obs_t o; int tc[$]; int t_drop;
    apply_reset(1'b1, 1'b1, 1'b0, 1'b0);
    for (int s = 1; s <= 6; s++) exp_a.push_back(ev(3'(s), 2'd0));
    wait_obs(1'b0, 6, 100);
    repeat (5) @(posedge clk);
    #2;
    lock_a = 1'b0; t_drop = cyc;
    exp_a.push_back(ev(3'd1, 2'd0));
    wait_obs(1'b0, 7, 20);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_tests++;
      if (obs_a.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL lockloss seq: got none want %h", e);
      end else begin
        o = obs_a.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL lockloss seq: got %h want %h", o.v, e); end
      end
    end
    n_tests++;
    if (tc[6] - t_drop > 3) begin n_fail++; $display("FAIL lockloss delay: got %0d want <= 3", tc[6] - t_drop); end
    lock_a = 1'b1;
    for (int s = 2; s <= 6; s++) exp_a.push_back(ev(3'(s), 2'd0));
    wait_obs(1'b0, 5, 100);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_tests++;
      if (obs_a.size() == 0) begin
        n_fail++; tc.push_back(-100000); $display("FAIL lockloss redo: got none want %h", e);
      end else begin
        o = obs_a.pop_front(); tc.push_back(o.c);
        if (o.v !== e) begin n_fail++; $display("FAIL lockloss redo: got %h want %h", o.v, e); end
      end
    end
    n_tests++;
    if (tc[8] - tc[7] !== LSC) begin n_fail++; $display("FAIL lockloss requal: got %0d want %0d", tc[8] - tc[7], LSC); end
  endtask

  task automatic test_calib_drop();
    logic [8:0] e; obs_t o;
    apply_reset(1'b0, 1'b0, 1'b1, 1'b0);
    exp_b.push_back(ev(3'd1, 2'd0)); exp_b.push_back(ev(3'd2, 2'd0));
    exp_b.push_back(ev(3'd3, 2'd0)); exp_b.push_back(ev(3'd4, 2'd0));
    exp_b.push_back(ev(3'd3, 2'd1)); exp_b.push_back(ev(3'd4, 2'd1));
    wait_obs(1'b1, 6, 400);
    cal_b = 1'b1;
    exp_b.push_back(ev(3'd5, 2'd1)); exp_b.push_back(ev(3'd6, 2'd1));
    wait_obs(1'b1, 8, 50);
    repeat (3) @(posedge clk);
    #2;
    cal_b = 1'b0;
    exp_b.push_back(ev(3'd3, 2'd1));
    wait_obs(1'b1, 9, 20);
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front(); n_tests++;
      if (obs_b.size() == 0) begin
        n_fail++; $display("FAIL caldrop seq: got none want %h", e);
      end else begin
        o = obs_b.pop_front();
        if (o.v !== e) begin n_fail++; $display("FAIL caldrop seq: got %h want %h", o.v, e); end
      end
    end
  endtask

  task automatic test_reset_midcal();
    logic [8:0] e; obs_t o;
    apply_reset(1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 1; s <= 4; s++) exp_a.push_back(ev(3'(s), 2'd0));
    wait_obs(1'b0, 4, 100);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_tests++;
      if (obs_a.size() == 0) begin
        n_fail++; $display("FAIL midcal seq: got none want %h", e);
      end else begin
        o = obs_a.pop_front();
        if (o.v !== e) begin n_fail++; $display("FAIL midcal seq: got %h want %h", o.v, e); end
      end
    end
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({st_a, mrst_a, fbr_a, ini_a, err_a, rc_a} !== ev(3'd0, 2'd0)) begin
      n_fail++; $display("FAIL midcal reset: got %h want %h", {st_a, mrst_a, fbr_a, ini_a, err_a, rc_a}, ev(3'd0, 2'd0));
    end
  endtask

  initial begin
    reset = 1'b1;
    lock_a = 1'b0; cal_a = 1'b0; lock_b = 1'b0; cal_b = 1'b0;
    test_reset();
    test_min_latency();
    test_nominal();
    test_lock_glitch();
    test_timeout_err();
    test_retry_success();
    test_timeout_boundary();
    test_lock_loss();
    test_calib_drop();
    test_reset_midcal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by cycle %0d want finish", cyc);
    $fatal(1);
  end

endmodule
